triangle_dispatcher: RTL
========================

TRIANGLE_DISPATCHER -- requirements
Module: triangle_dispatcher

Interface
REQ-001 SHALL have parameter MAX_TRIS, default 24: triangle slots in the sorted list.
REQ-002 SHALL have parameter NUM_VERTS, default 18: projected vertex slots.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports: clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port frame_start, input, 1, one-cycle request to dispatch a new frame.
REQ-006 SHALL have port num_triangles, input, 5, valid entries in triangles_sorted.
REQ-007 SHALL have port triangles_sorted[0:MAX_TRIS-1], input, triangle_t, triangle list in back-to-front order.
REQ-008 SHALL have port sorted_indices[0:MAX_TRIS-1], input, 5 each, original triangle IDs.
REQ-009 SHALL have port vertices_2d[0:NUM_VERTS-1], input, vertex_2d_t, projected vertices.
REQ-010 SHALL have port tri_valid, output, 1, a triangle is presented to the rasterizer.
REQ-011 SHALL have port tri_ready, input, 1, rasterizer accepts the triangle.
REQ-012 SHALL have ports tri_a, tri_b, tri_c, output, vertex_2d_t, resolved vertices of the presented triangle.
REQ-013 SHALL have port tri_id, output, 5, sorted_indices entry of the presented triangle.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when the frame completes.
REQ-016 SHALL have port bad_vertex, output, 1, sticky flag set when a vertex index is >= NUM_VERTS.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, ISSUE and DONE.
REQ-018 IDLE: on frame_start=1, SHALL go to LOAD and clear bad_vertex.
REQ-019 LOAD (1 cycle): SHALL snapshot triangles_sorted, sorted_indices, vertices_2d, and count = min(num_triangles, MAX_TRIS) into internal registers. Later input changes SHALL NOT affect the frame.
REQ-020 LOAD -> DONE if count==0; otherwise LOAD -> ISSUE with ptr=0.
REQ-021 ISSUE: tri_valid=1, and tri_a/b/c, tri_id SHALL come from registers for snapshot entry ptr, resolved through the v0/v1/v2 indices.
REQ-022 First tri_valid SHALL be asserted exactly 2 cycles after the cycle in which frame_start is sampled.
REQ-023 Handshake: transfer occurs on tri_valid&&tri_ready. Outputs SHALL hold stable while tri_valid=1 and tri_ready=0.
REQ-024 On transfer with ptr<count-1: ptr+1, next triangle presented the following cycle. With tri_ready held high, throughput SHALL be 1 triangle per cycle.
REQ-025 On transfer with ptr==count-1: tri_valid SHALL deassert next cycle and the FSM SHALL enter DONE.
REQ-026 DONE: frame_done=1 for exactly one cycle, then IDLE.
REQ-027 frame_start while busy=1 (LOAD/ISSUE/DONE) SHALL be ignored, with no queuing and no effect on the current frame.
REQ-028 A vertex index >= NUM_VERTS SHALL substitute vertices_2d snapshot entry 0 and set bad_vertex, held until the next accepted frame_start or reset.
REQ-029 num_triangles > MAX_TRIS SHALL be clamped to MAX_TRIS. Triangles SHALL be issued strictly in ascending ptr order, with no skips or repeats.
REQ-030 tri_valid SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-031 With rst_n=0 at a clock edge: state=IDLE, ptr=0, count=0, tri_valid=0, busy=0, frame_done=0, bad_vertex=0, tri_a/b/c/tri_id=0.
REQ-032 Reset mid-frame SHALL abort immediately with no frame_done pulse. The first frame_start after release SHALL start a fresh frame.

Verification
REQ-033 num_triangles=3, tri_ready=1, frame_start at cycle 0 -> tri_valid cycles 2-4 with tri_id = sorted_indices[0..2]; frame_done at cycle 5; busy cycles 1-5.
REQ-034 num_triangles=2, tri_ready low for 3 cycles on the first triangle -> tri_a/b/c/tri_id stable for 4 cycles; the second triangle is presented the cycle after acceptance.
REQ-035 num_triangles=0 -> tri_valid never asserted; frame_done at cycle 2 after frame_start.
REQ-036 num_triangles=30 -> exactly 24 transfers, then a frame_done pulse.
REQ-037 Triangle with v1=20 -> tri_b = vertices_2d[0]; bad_vertex=1 until the next frame_start.
REQ-038 rst_n=0 during ISSUE at ptr=5, plus frame_start pulsed while busy -> outputs zeroed, no frame_done; the second frame_start is ignored.

Source files
------------

// File: rtl/triangle_dispatcher.sv
// Frame-level triangle dispatcher: snapshots a sorted triangle list and its vertices,
// then streams resolved triangles to the rasterizer over a valid/ready handshake.
package triangle_dispatcher_pkg;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } vertex_2d_t;

  typedef struct packed {
    logic [4:0] v0;
    logic [4:0] v1;
    logic [4:0] v2;
  } triangle_t;
endpackage

module triangle_dispatcher
  import triangle_dispatcher_pkg::*;
#(
  parameter int unsigned MAX_TRIS  = 24,
  parameter int unsigned NUM_VERTS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [4:0] num_triangles,
  input  triangle_t  triangles_sorted [0:MAX_TRIS-1],
  input  logic [4:0] sorted_indices   [0:MAX_TRIS-1],
  input  vertex_2d_t vertices_2d      [0:NUM_VERTS-1],
  output logic       tri_valid,
  input  logic       tri_ready,
  output vertex_2d_t tri_a,
  output vertex_2d_t tri_b,
  output vertex_2d_t tri_c,
  output logic [4:0] tri_id,
  output logic       busy,
  output logic       frame_done,
  output logic       bad_vertex
);

  localparam int unsigned CW = $clog2(MAX_TRIS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ptr, count, load_count;
  logic          last, xfer;
  logic          bad_a, bad_b, bad_c;
  triangle_t     cur;

  triangle_t  snap_t  [0:MAX_TRIS-1];
  logic [4:0] snap_id [0:MAX_TRIS-1];
  vertex_2d_t snap_v  [0:NUM_VERTS-1];

  always_comb begin
    if (32'(num_triangles) > MAX_TRIS) load_count = CW'(MAX_TRIS);
    else                               load_count = CW'(num_triangles);
  end

  assign cur   = snap_t[ptr];
  assign bad_a = 32'(cur.v0) >= NUM_VERTS;
  assign bad_b = 32'(cur.v1) >= NUM_VERTS;
  assign bad_c = 32'(cur.v2) >= NUM_VERTS;
  assign last  = (ptr == count - CW'(1));
  assign xfer  = (state == ISSUE) && tri_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = LOAD;
      LOAD:    state_nxt = (load_count == '0) ? DONE : ISSUE;
      ISSUE:   if (xfer && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range vertex indices fall back to snapshot vertex 0.
  always_comb begin
    tri_valid  = (state == ISSUE);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    tri_a      = '0;
    tri_b      = '0;
    tri_c      = '0;
    tri_id     = '0;
    if (state == ISSUE) begin
      tri_a  = snap_v[bad_a ? 5'd0 : cur.v0];
      tri_b  = snap_v[bad_b ? 5'd0 : cur.v1];
      tri_c  = snap_v[bad_c ? 5'd0 : cur.v2];
      tri_id = snap_id[ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      count      <= '0;
      bad_vertex <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:  if (frame_start) bad_vertex <= 1'b0;
        LOAD: begin
          count <= load_count;
          ptr   <= '0;
        end
        ISSUE: begin
          if (bad_a || bad_b || bad_c) bad_vertex <= 1'b1;
          if (xfer && !last) ptr <= ptr + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Snapshot contents are never visible outside ISSUE, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      snap_t  <= triangles_sorted;
      snap_id <= sorted_indices;
      snap_v  <= vertices_2d;
    end
  end

endmodule
